uart_tx_feeder: RTL and testbench
=================================

// Module: uart_tx_feeder
// PURPOSE
//  Byte buffer and sequencer directly upstream of the UART RS-232 transmitter.
//  Producers (e.g. NPU result readout) push bytes into a FIFO at clock rate.
//  The block hands bytes one at a time to the transmitter over TxEn/TxData/TxDone.
//  It adds a completion watchdog and sticky error flags.
// PARAMETERS
//  DEPTH    16       FIFO entries; power of two, >=2
//  AW       4        pointer width, log2(DEPTH)
//  TIMEOUT  1048576  max Clk cycles in WAIT_DONE before watchdog abort; >=2
// PORTS
//  Clk       in   1       system clock; same clock as transmitter Clk/Tick source
//  Rst_n     in   1       asynchronous, active-low reset
//  WrEn      in   1       push WrData this cycle (ignored when Full)
//  WrData    in   8       byte to queue
//  ClrErr    in   1       clears Overflow and Timeout sticky flags
//  TxDone    in   1       transmitter done level (from transmitter)
//  TxEn      out  1       one-cycle start request to transmitter
//  TxData    out  8       byte under transmission; held stable until WAIT_CLR exits
//  Full      out  1       Count==DEPTH
//  Empty     out  1       Count==0
//  Count     out  AW+1    bytes queued, excluding the byte in flight
//  Busy      out  1       FSM not in IDLE
//  Overflow  out  1       sticky: WrEn seen while Full
//  Timeout   out  1       sticky: watchdog fired
// BEHAVIOUR
//  Reset: all outputs 0 except Empty=1; pointers/Count=0; FSM=IDLE; TxDone_q=0.
//  FIFO: registered write, pop on LOAD; Count updates on the same edge.
//  - Write and pop on the same edge: Count unchanged; both succeed.
//  - Write while Full: dropped, Overflow<=1. A pop on that edge does not admit it.
//  - Pointers wrap modulo DEPTH.
//  TxDone_q: TxDone registered each cycle; rise = TxDone & !TxDone_q.
//  FSM (one-hot or binary; states fixed):
//   IDLE      : if !Empty -> LOAD
//   LOAD      : TxData<=mem[rd_ptr]; rd_ptr++, Count--; -> START
//   START     : TxEn=1 for exactly this cycle; wd counter<=0; -> WAIT_DONE
//   WAIT_DONE : wd++ each cycle
//               - on rise -> WAIT_CLR
//               - if wd==TIMEOUT-1 -> Timeout<=1, -> WAIT_CLR
//   WAIT_CLR  : stay while TxDone==1; when TxDone==0 -> IDLE
//               (TxDone stays high until the next Tick; re-asserting TxEn earlier
//               would abort the next byte)
//  Latency: WrEn on edge N into an empty, idle block.
//  - LOAD on edge N+1, TxEn high in cycle after edge N+2 (START).
//  Back-to-back: next LOAD 1 cycle after WAIT_CLR exits; no TxEn while TxDone=1.
//  TxEn is a registered output, never combinational from inputs.
//  ClrErr beats a same-cycle set: clear wins, then the flag sets again on a later event.
//  Reset mid-transfer: FIFO emptied, TxEn/TxData=0 immediately (async).
//  - The transmitter is reset by the same Rst_n.
//  Timeout abort drops the in-flight byte; the queue is preserved and draining
//  continues after WAIT_CLR.
// TESTING
//  1. Push 0xA5 into an idle block -> TxEn one-cycle pulse 2 cycles later, TxData=0xA5.
//     Model TxDone high 160 cycles later for 3 cycles -> Busy falls 1 cycle after TxDone low.
//  2. Push 0x01..0x10 back-to-back (DEPTH=16).
//     -> Full=1 after 16th push (before first LOAD); Count returns to 0 after LOAD pops.
//     -> 16 TxEn pulses, data in order, each only after TxDone low.
//  3. Hold Full, push 0xFF -> Overflow=1, 0xFF never transmitted; ClrErr -> Overflow=0.
//  4. Push and pop on the same edge at Count=5 -> Count stays 5; pointer wrap past 15->0 keeps order.
//  5. TxDone never asserted, TIMEOUT=64 -> Timeout=1 64 cycles after START.
//     -> The next queued byte starts without a TxDone handshake.
//  6. Assert Rst_n=0 during WAIT_DONE with 3 bytes queued.
//     -> TxEn=0, Empty=1, Busy=0 asynchronously; no TxEn after release until a new push.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder
//   Byte FIFO and hand-off sequencer sitting in front of the RS-232 UART
//   transmitter. Producers push bytes at clock rate; the sequencer pops one
//   byte at a time, pulses TxEn for one cycle, then waits for the
//   transmitter's TxDone level to rise and fall before starting the next byte.
//   A watchdog aborts a byte whose TxDone never arrives, and two sticky error
//   flags record dropped writes and watchdog aborts.
//
// Ports
//   Clk, Rst_n      clock, asynchronous active-low reset
//   WrEn, WrData    push a byte (ignored when Full)
//   ClrErr          clear Overflow / Timeout (wins over a same-cycle set)
//   TxDone          transmitter done level
//   TxEn, TxData    one-cycle start pulse and byte under transmission
//   Full, Empty     FIFO status
//   Count           bytes queued, not counting the byte in flight
//   Busy            sequencer not idle
//   Overflow        sticky: write attempted while Full
//   Timeout         sticky: watchdog fired
// ---------------------------------------------------------------------------
module uart_tx_feeder #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 1048576
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          WrEn,
    input  logic [7:0]    WrData,
    input  logic          ClrErr,
    input  logic          TxDone,
    output logic          TxEn,
    output logic [7:0]    TxData,
    output logic          Full,
    output logic          Empty,
    output logic [AW:0]   Count,
    output logic          Busy,
    output logic          Overflow,
    output logic          Timeout
);

    // Watchdog counter only has to reach TIMEOUT-1.
    localparam int              WDW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [AW:0]     DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_DONE,
        S_WAIT_CLR
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_en_q, tx_en_d;
    logic [WDW-1:0]  wd_q, wd_d;
    logic            tx_done_q, tx_done_d;
    logic            overflow_q, overflow_d;
    logic            timeout_q, timeout_d;

    logic            full, empty;
    logic            wr_accept;
    logic            pop;
    logic            done_rise;
    logic            timeout_set;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    // Fullness is judged before any same-edge pop, so a pop never admits
    // a write that arrived while Full.
    assign wr_accept = WrEn & ~full;
    assign done_rise = TxDone & ~tx_done_q;

    // -----------------------------------------------------------------------
    // Sequencer next-state / outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        tx_en_d     = 1'b0;
        wd_d        = wd_q;
        pop         = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) state_d = S_LOAD;
            end
            S_LOAD: begin
                pop       = 1'b1;
                tx_data_d = mem_q[rd_ptr_q];
                // TxEn is registered: raising it here makes it high for
                // exactly the START cycle.
                tx_en_d   = 1'b1;
                state_d   = S_START;
            end
            S_START: begin
                wd_d    = '0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                wd_d = wd_q + WDW'(1);
                // A genuine completion on the last watchdog cycle still
                // counts as success.
                if (done_rise) begin
                    state_d = S_WAIT_CLR;
                end else if (wd_q == WD_LAST) begin
                    timeout_set = 1'b1;
                    state_d     = S_WAIT_CLR;
                end
            end
            S_WAIT_CLR: begin
                // TxDone stays high until the transmitter's next Tick; a new
                // TxEn before it drops would abort the next byte.
                if (!TxDone) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FIFO bookkeeping and sticky flags
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop       ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
        tx_done_d  = TxDone;
        overflow_d = ClrErr ? 1'b0 : (overflow_q | (WrEn & full));
        timeout_d  = ClrErr ? 1'b0 : (timeout_q | timeout_set);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_data_q  <= '0;
            tx_en_q    <= 1'b0;
            wd_q       <= '0;
            tx_done_q  <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_data_q  <= tx_data_d;
            tx_en_q    <= tx_en_d;
            wd_q       <= wd_d;
            tx_done_q  <= tx_done_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge Clk) begin
        if (wr_accept) mem_q[wr_ptr_q] <= WrData;
    end

    assign TxEn     = tx_en_q;
    assign TxData   = tx_data_q;
    assign Full     = full;
    assign Empty    = empty;
    assign Count    = count_q;
    assign Busy     = (state_q != S_IDLE);
    assign Overflow = overflow_q;
    assign Timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT (long watchdog) and watchdog DUT (TIMEOUT=64)
    logic       rst_n, wr_en, clr_err;
    logic       tx_done = 1'b0;
    logic [7:0] wr_data;
    logic       tx_en, full, empty, busy, ovf, tmo;
    logic [7:0] tx_data;
    logic [4:0] count;

    logic       wr2, clr2, tx_done2;
    logic [7:0] wd2;
    logic       tx_en2, full2, empty2, busy2, ovf2, tmo2;
    logic [7:0] tx_data2;
    logic [4:0] count2;

    uart_tx_feeder #(.DEPTH(16), .AW(4), .TIMEOUT(1024)) dut (
        .Clk(clk), .Rst_n(rst_n), .WrEn(wr_en), .WrData(wr_data),
        .ClrErr(clr_err), .TxDone(tx_done), .TxEn(tx_en), .TxData(tx_data),
        .Full(full), .Empty(empty), .Count(count), .Busy(busy),
        .Overflow(ovf), .Timeout(tmo));

    uart_tx_feeder #(.DEPTH(16), .AW(4), .TIMEOUT(64)) dut_wd (
        .Clk(clk), .Rst_n(rst_n), .WrEn(wr2), .WrData(wd2),
        .ClrErr(clr2), .TxDone(tx_done2), .TxEn(tx_en2), .TxData(tx_data2),
        .Full(full2), .Empty(empty2), .Count(count2), .Busy(busy2),
        .Overflow(ovf2), .Timeout(tmo2));

    int checks = 0;
    int errors = 0;
    int lat    = 160;

    logic [7:0] sb[$];
    typedef struct {
        logic [7:0] data;
        logic       done_lvl;
        logic       prev_en;
    } obs_t;
    obs_t obs_q[$];
    logic prev_en = 1'b0;

    // Record every TxEn pulse with the TxDone level and previous TxEn.
    always @(posedge clk) begin
        #1;
        if (tx_en === 1'b1) obs_q.push_back('{tx_data, tx_done, prev_en});
        prev_en <= tx_en;
    end

    // Transmitter model: TxDone high for 3 cycles, lat cycles after TxEn.
    always begin
        @(negedge clk);
        if (!rst_n) begin
            tx_done = 1'b0;
        end else if (tx_en) begin
            for (int i = 0; i < lat; i++) begin
                @(negedge clk);
                if (!rst_n) break;
            end
            if (rst_n) begin
                tx_done = 1'b1;
                repeat (3) @(negedge clk);
                tx_done = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input logic lvl, input int budget, input string tag);
        int n;
        n = 0;
        while (tx_done !== lvl && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        chk(tag, 32'(tx_done), 32'(lvl));
    endtask

    task automatic wait_obs(input int num, input int budget, input string tag);
        int n;
        n = 0;
        while (obs_q.size() < num && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        chk(tag, 32'(obs_q.size() >= num), 32'd1);
    endtask

    // Pop scoreboard against observed pulses: data in order, TxDone low and
    // TxEn low in the previous cycle at each start; nothing extra sent.
    task automatic drain(input string tag);
        logic [7:0] e;
        obs_t       o;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            if (obs_q.size() == 0) begin
                chk({tag, "_missing"}, 32'(obs_q.size()), 32'd1);
            end else begin
                o = obs_q.pop_front();
                chk(tag, 32'({o.done_lvl, o.prev_en, o.data}), 32'({2'b00, e}));
            end
        end
        chk({tag, "_extra"}, 32'(obs_q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clr_err = 1'b0;
        wr2 = 1'b0; wd2 = 8'h00; clr2 = 1'b0; tx_done2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset", 32'({tx_en, tx_data, full, empty, count, busy, ovf, tmo}),
            32'({1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0}));
        chk("reset_wd", 32'({tx_en2, tx_data2, full2, empty2, count2, busy2, ovf2, tmo2}),
            32'({1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0}));
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single byte latency and handshake
        lat = 160;
        wr_en = 1'b1; wr_data = 8'hA5; sb.push_back(8'hA5);
        @(negedge clk); wr_en = 1'b0;
        chk("t1_queued", 32'({empty, count, tx_en}), 32'({1'b0, 5'd1, 1'b0}));
        @(negedge clk);
        chk("t1_load", 32'({busy, tx_en, count}), 32'({1'b1, 1'b0, 5'd1}));
        @(negedge clk);
        chk("t1_start", 32'({tx_en, tx_data, count}), 32'({1'b1, 8'hA5, 5'd0}));
        @(negedge clk);
        chk("t1_pulse", 32'(tx_en), 32'd0);
        drain("t1_data");
        wait_done(1'b1, 300, "t1_done_hi");
        chk("t1_busy_hi", 32'(busy), 32'd1);
        wait_done(1'b0, 20, "t1_done_lo");
        chk("t1_idle", 32'({busy, empty, tx_en}), 32'({1'b0, 1'b1, 1'b0}));

        // 2/3: fill while a byte is in flight, overflow, clear priority
        lat = 40;
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'h00; sb.push_back(8'h00);
        @(negedge clk);
        for (int i = 1; i <= 16; i++) begin
            wr_data = i[7:0]; sb.push_back(i[7:0]);
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk("t2_full", 32'({full, count, empty}), 32'({1'b1, 5'd16, 1'b0}));
        wr_en = 1'b1; wr_data = 8'hFF;
        @(negedge clk); wr_en = 1'b0;
        chk("t3_ovf_set", 32'({ovf, count}), 32'({1'b1, 5'd16}));
        clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0;
        chk("t3_ovf_clr", 32'(ovf), 32'd0);
        wr_en = 1'b1; clr_err = 1'b1;
        @(negedge clk); wr_en = 1'b0; clr_err = 1'b0;
        chk("t3_clr_wins", 32'({ovf, count}), 32'({1'b0, 5'd16}));
        wr_en = 1'b1;
        @(negedge clk); wr_en = 1'b0;
        chk("t3_ovf_again", 32'(ovf), 32'd1);
        clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0;
        wait_obs(sb.size(), 1500, "t2_obs");
        drain("t2_data");
        chk("t2_drained", 32'({empty, count}), 32'({1'b1, 5'd0}));
        wait_done(1'b1, 100, "t2_done_hi");
        wait_done(1'b0, 20, "t2_done_lo");

        // 4: push and pop on the same edge at Count=5, pointer wrap
        lat = 30;
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'h30; sb.push_back(8'h30);
        @(negedge clk);
        for (int i = 8'h31; i <= 8'h35; i++) begin
            wr_data = i[7:0]; sb.push_back(i[7:0]);
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk("t4_cnt5", 32'(count), 32'd5);
        wait_done(1'b1, 100, "t4_done_hi");
        wait_done(1'b0, 20, "t4_done_lo");
        @(posedge clk); #2;               // FSM now in LOAD
        wr_en = 1'b1; wr_data = 8'h36; sb.push_back(8'h36);
        @(posedge clk); #2;
        wr_en = 1'b0;
        chk("t4_same_edge", 32'({count, tx_en, tx_data}), 32'({5'd5, 1'b1, 8'h31}));
        @(negedge clk);
        wr_en = 1'b1;
        for (int i = 8'h37; i <= 8'h40; i++) begin
            wr_data = i[7:0]; sb.push_back(i[7:0]);
            @(negedge clk);
        end
        wr_en = 1'b0;
        wait_obs(sb.size(), 1200, "t4_obs");
        drain("t4_data");
        wait_done(1'b1, 100, "t4_done_hi2");
        wait_done(1'b0, 20, "t4_done_lo2");

        // 5: watchdog on the TIMEOUT=64 instance, TxDone never rises
        @(negedge clk);
        wr2 = 1'b1; wd2 = 8'h55;
        @(negedge clk); wd2 = 8'h66;
        @(negedge clk); wr2 = 1'b0;
        @(negedge clk);
        chk("t5_start", 32'({tx_en2, tx_data2}), 32'({1'b1, 8'h55}));
        repeat (64) @(negedge clk);
        chk("t5_before", 32'(tmo2), 32'd0);
        @(negedge clk);
        chk("t5_fired", 32'({tmo2, tx_en2}), 32'({1'b1, 1'b0}));
        repeat (3) @(negedge clk);
        chk("t5_next", 32'({tx_en2, tx_data2, count2}), 32'({1'b1, 8'h66, 5'd0}));
        clr2 = 1'b1;
        @(negedge clk); clr2 = 1'b0;
        chk("t5_clr", 32'(tmo2), 32'd0);

        // 6: reset while waiting for TxDone with 3 bytes queued
        lat = 100;
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'h70; sb.push_back(8'h70);
        for (int i = 8'h71; i <= 8'h73; i++) begin
            @(negedge clk); wr_data = i[7:0];
        end
        @(negedge clk); wr_en = 1'b0;
        wait_obs(1, 10, "t6_obs");
        drain("t6_data");
        repeat (5) @(negedge clk);
        chk("t6_pre", 32'({busy, count, tx_data}), 32'({1'b1, 5'd3, 8'h70}));
        #2 rst_n = 1'b0;
        #1 chk("t6_async", 32'({tx_en, tx_data, empty, busy, count, full}),
               32'({1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0}));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("t6_no_txen", 32'(obs_q.size()), 32'd0);
        chk("t6_idle", 32'({busy, empty}), 32'({1'b0, 1'b1}));
        wr_en = 1'b1; wr_data = 8'h7A; sb.push_back(8'h7A);
        @(negedge clk); wr_en = 1'b0;
        wait_obs(1, 10, "t6_obs2");
        drain("t6_new");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
